// File: rtl/cobra_pkg.sv
// Shared types and constants for the cobra snake datapath.
// Direction codes match the encoding held by the cobra_dir register.
package cobra_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Coordinates are carried at a fixed width wide enough for any grid up to 256 cells.
  localparam int unsigned COORD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Opposite directions share the axis bit and differ in the sign bit.
  function automatic logic is_reverse(input logic [1:0] dir_a, input logic [1:0] dir_b);
    return (dir_a[1] == dir_b[1]) && (dir_a[0] != dir_b[0]);
  endfunction

endpackage

// File: rtl/cobra_move_if.sv
// Control, status and renderer-query signals of cobra_move.
// slave is the snake engine side; master is the game/renderer side.
interface cobra_move_if #(
  parameter int GRID_W  = 32,
  parameter int GRID_H  = 24,
  parameter int MAX_LEN = 16
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);

  logic [1:0]    cobra_dir;
  logic          start;
  logic          grow;
  logic [XW-1:0] query_x;
  logic [YW-1:0] query_y;
  logic          query_hit;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] length;
  logic          step;
  logic          game_over;

  modport master (
    output cobra_dir, start, grow, query_x, query_y,
    input  query_hit, head_x, head_y, length, step, game_over
  );

  modport slave (
    input  cobra_dir, start, grow, query_x, query_y,
    output query_hit, head_x, head_y, length, step, game_over
  );
endinterface

// File: rtl/cobra_tick.sv
// Movement tick divider: counts 0..TICK_DIV-1 while enabled and flags the
// wrap cycle with a combinational tick; clr forces the count back to zero.
module cobra_tick #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && !clr && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/cobra_move.sv
// Snake body engine: steps the head once per tick, grows, detects collisions
// and answers renderer occupancy queries. Define COBRA_WRAP_EN for wrap-around borders.
module cobra_move
  import cobra_pkg::*;
#(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 5000000
) (
  input logic         clk,
  input logic         rst_n,
  cobra_move_if.slave bus
);
  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [LW-1:0] INIT_L = LW'(INIT_LEN);
  localparam logic [LW-1:0] MAX_L  = LW'(MAX_LEN);
`ifdef COBRA_WRAP_EN
  localparam logic WALL_EN = 1'b0;
`else
  localparam logic WALL_EN = 1'b1;
`endif

  function automatic coord_t init_seg(input int unsigned i);
    return '{x: COORD_W'(GRID_W / 2 - int'(i)), y: COORD_W'(GRID_H / 2)};
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  coord_t        seg_q [MAX_LEN];
  coord_t        seg_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  logic          grow_pend_q, grow_pend_d;
  logic          step_q, step_d;
  logic          game_over_q, game_over_d;
  logic          query_hit_q, query_hit_d;

  logic        tick;
  logic [1:0]  dir_sel;
  coord_t      new_head;
  coord_t      query_c;
  logic        at_edge;
  logic        self_hit;
  logic        eff_grow;
  int unsigned cmp_lim;

  cobra_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == RUN),
    .clr  ((state_q == IDLE) && bus.start),
    .tick (tick)
  );

  // Candidate move; the edge case already produces the wrapped coordinate.
  always_comb begin
    dir_sel  = is_reverse(bus.cobra_dir, dir_q) ? dir_q : bus.cobra_dir;
    new_head = seg_q[0];
    at_edge  = 1'b0;
    case (dir_sel)
      DIR_UP: begin
        at_edge    = (seg_q[0].y == '0);
        new_head.y = at_edge ? Y_MAX : seg_q[0].y - COORD_W'(1);
      end
      DIR_DOWN: begin
        at_edge    = (seg_q[0].y == Y_MAX);
        new_head.y = at_edge ? '0 : seg_q[0].y + COORD_W'(1);
      end
      DIR_LEFT: begin
        at_edge    = (seg_q[0].x == '0);
        new_head.x = at_edge ? X_MAX : seg_q[0].x - COORD_W'(1);
      end
      default: begin
        at_edge    = (seg_q[0].x == X_MAX);
        new_head.x = at_edge ? '0 : seg_q[0].x + COORD_W'(1);
      end
    endcase

    eff_grow = (bus.grow || grow_pend_q) && (len_q < MAX_L);
    // Without growth the tail cell is vacated, so it is excluded from the check.
    cmp_lim  = 32'(len_q) + 32'(eff_grow);
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i + 1 < cmp_lim) && (seg_q[i] == new_head)) begin
        self_hit = 1'b1;
      end
    end

    query_c     = '{x: COORD_W'(bus.query_x), y: COORD_W'(bus.query_y)};
    query_hit_d = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i < 32'(len_q)) && (seg_q[i] == query_c)) begin
        query_hit_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    seg_d       = seg_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q;
    step_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        grow_pend_d = 1'b0;
        if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (tick) begin
          grow_pend_d = 1'b0;
          if ((at_edge && WALL_EN) || self_hit) begin
            state_d = DEAD;
          end else begin
            dir_d = dir_sel;
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
              seg_d[i] = seg_q[i-1];
            end
            seg_d[0] = new_head;
            len_d    = len_q + LW'(eff_grow);
            step_d   = 1'b1;
          end
        end else if (bus.grow) begin
          grow_pend_d = (len_q != MAX_L);
        end
      end
      DEAD: begin
        grow_pend_d = 1'b0;
        if (bus.start) begin
          state_d = IDLE;
          dir_d   = DIR_RIGHT;
          len_d   = INIT_L;
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            seg_d[i] = init_seg(i);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    game_over_d = (state_d == DEAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dir_q       <= DIR_RIGHT;
      len_q       <= INIT_L;
      grow_pend_q <= 1'b0;
      step_q      <= 1'b0;
      game_over_q <= 1'b0;
      query_hit_q <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= init_seg(i);
      end
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
      step_q      <= step_d;
      game_over_q <= game_over_d;
      query_hit_q <= query_hit_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.head_x    = seg_q[0].x[XW-1:0];
  assign bus.head_y    = seg_q[0].y[YW-1:0];
  assign bus.length    = len_q;
  assign bus.step      = step_q;
  assign bus.game_over = game_over_q;
  assign bus.query_hit = query_hit_q;
endmodule

// File: tb/tb_cobra_move.sv
// Directed bench for cobra_move on an 8x8 grid, TICK_DIV=4, INIT_LEN=3, MAX_LEN=6.
module tb_cobra_move;
  import cobra_pkg::*;

  localparam int GW = 8;
  localparam int GH = 8;
  localparam int ML = 6;
  localparam int IL = 3;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int failures = 0;

  cobra_move_if #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML)) bus ();

  cobra_move #(
    .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .INIT_LEN(IL), .TICK_DIV(TD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_move(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.step !== 1'b1 && bus.game_over !== 1'b1 && n < 20);
  endtask

  task automatic test_reset();
    bus.cobra_dir = DIR_RIGHT;
    bus.start = 1'b0;
    bus.grow = 1'b0;
    bus.query_x = 3'd3;
    bus.query_y = 3'd4;
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.step, bus.game_over, bus.query_hit}
        !== {3'd4, 3'd4, 3'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got head=(%0d,%0d) len=%0d step=%b go=%b hit=%b expected (4,4) 3 0 0 0",
               bus.head_x, bus.head_y, bus.length, bus.step, bus.game_over, bus.query_hit);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b1) begin
      failures++; $display("FAIL query_3_4: got %b expected 1", bus.query_hit);
    end
    bus.query_x = 3'd2;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b1) begin
      failures++; $display("FAIL query_2_4: got %b expected 1", bus.query_hit);
    end
    bus.query_x = 3'd1;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b0) begin
      failures++; $display("FAIL query_1_4_beyond_len: got %b expected 0", bus.query_hit);
    end
    bus.query_x = 3'd0;
    bus.query_y = 3'd0;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b0) begin
      failures++; $display("FAIL query_0_0: got %b expected 0", bus.query_hit);
    end
    repeat (6) cyc();
    checks++;
    if ({bus.head_x, bus.head_y, bus.step} !== {3'd4, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL idle_hold: got head=(%0d,%0d) step=%b expected (4,4) 0", bus.head_x, bus.head_y, bus.step);
    end
  endtask

  task automatic test_start();
    int n;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    wait_move(n);
    checks++;
    if (n != TD) begin
      failures++; $display("FAIL first_step_latency: got %0d cycles expected %0d", n, TD);
    end
    checks++;
    if ({bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 3'd5, 3'd4, 3'd3}) begin
      failures++;
      $display("FAIL first_step: got step=%b head=(%0d,%0d) len=%0d expected 1 (5,4) 3",
               bus.step, bus.head_x, bus.head_y, bus.length);
    end
    cyc();
    checks++;
    if (bus.step !== 1'b0) begin
      failures++; $display("FAIL step_width: got %b expected 0", bus.step);
    end
  endtask

  task automatic test_reverse();
    int n;
    bus.cobra_dir = DIR_LEFT;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y} !== {1'b1, 3'd6, 3'd4}) begin
      failures++;
      $display("FAIL reverse_ignored: got step=%b head=(%0d,%0d) expected 1 (6,4)", bus.step, bus.head_x, bus.head_y);
    end
    bus.cobra_dir = DIR_UP;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y} !== {1'b1, 3'd6, 3'd3}) begin
      failures++;
      $display("FAIL turn_up: got step=%b head=(%0d,%0d) expected 1 (6,3)", bus.step, bus.head_x, bus.head_y);
    end
  endtask

  task automatic test_grow();
    int n;
    bus.cobra_dir = DIR_LEFT;
    bus.grow = 1'b1;
    cyc();
    bus.grow = 1'b0;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 3'd5, 3'd3, 3'd4}) begin
      failures++;
      $display("FAIL grow_pending: got step=%b head=(%0d,%0d) len=%0d expected 1 (5,3) 4",
               bus.step, bus.head_x, bus.head_y, bus.length);
    end
    // two pulses in one tick period add a single segment
    bus.grow = 1'b1; cyc(); bus.grow = 1'b0; cyc();
    bus.grow = 1'b1; cyc(); bus.grow = 1'b0;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 3'd4, 3'd3, 3'd5}) begin
      failures++;
      $display("FAIL grow_double: got step=%b head=(%0d,%0d) len=%0d expected 1 (4,3) 5",
               bus.step, bus.head_x, bus.head_y, bus.length);
    end
    repeat (3) cyc();
    bus.grow = 1'b1;
    cyc();
    bus.grow = 1'b0;
    checks++;
    if ({bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 3'd3, 3'd3, 3'd6}) begin
      failures++;
      $display("FAIL grow_on_tick: got step=%b head=(%0d,%0d) len=%0d expected 1 (3,3) 6",
               bus.step, bus.head_x, bus.head_y, bus.length);
    end
    bus.grow = 1'b1;
    cyc();
    bus.grow = 1'b0;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 3'd2, 3'd3, 3'd6}) begin
      failures++;
      $display("FAIL grow_at_max: got step=%b head=(%0d,%0d) len=%0d expected 1 (2,3) 6",
               bus.step, bus.head_x, bus.head_y, bus.length);
    end
  endtask

  task automatic test_self_collision();
    int n;
    bus.cobra_dir = DIR_DOWN;
    wait_move(n);
    bus.cobra_dir = DIR_RIGHT;
    wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y} !== {1'b1, 3'd3, 3'd4}) begin
      failures++;
      $display("FAIL coil_path: got step=%b head=(%0d,%0d) expected 1 (3,4)", bus.step, bus.head_x, bus.head_y);
    end
    bus.cobra_dir = DIR_UP;
    wait_move(n);
    checks++;
    if ({bus.game_over, bus.step, bus.head_x, bus.head_y, bus.length} !== {1'b1, 1'b0, 3'd3, 3'd4, 3'd6}) begin
      failures++;
      $display("FAIL self_hit: got go=%b step=%b head=(%0d,%0d) len=%0d expected 1 0 (3,4) 6",
               bus.game_over, bus.step, bus.head_x, bus.head_y, bus.length);
    end
    bus.query_x = 3'd5; bus.query_y = 3'd3;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b1) begin
      failures++; $display("FAIL dead_query_tail: got %b expected 1", bus.query_hit);
    end
    bus.query_x = 3'd6;
    cyc();
    checks++;
    if (bus.query_hit !== 1'b0) begin
      failures++; $display("FAIL dead_query_vacated: got %b expected 0", bus.query_hit);
    end
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    checks++;
    if ({bus.game_over, bus.head_x, bus.head_y, bus.length} !== {1'b0, 3'd4, 3'd4, 3'd3}) begin
      failures++;
      $display("FAIL restart: got go=%b head=(%0d,%0d) len=%0d expected 0 (4,4) 3",
               bus.game_over, bus.head_x, bus.head_y, bus.length);
    end
  endtask

  task automatic test_wall();
    int n;
    bus.cobra_dir = DIR_RIGHT;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    repeat (3) wait_move(n);
    checks++;
    if ({bus.step, bus.head_x, bus.head_y} !== {1'b1, 3'd7, 3'd4}) begin
      failures++;
      $display("FAIL reach_edge: got step=%b head=(%0d,%0d) expected 1 (7,4)", bus.step, bus.head_x, bus.head_y);
    end
    wait_move(n);
    checks++;
`ifdef COBRA_WRAP_EN
    if ({bus.game_over, bus.step, bus.head_x, bus.head_y} !== {1'b0, 1'b1, 3'd0, 3'd4}) begin
      failures++;
      $display("FAIL wrap_right: got go=%b step=%b head=(%0d,%0d) expected 0 1 (0,4)",
               bus.game_over, bus.step, bus.head_x, bus.head_y);
    end
`else
    if ({bus.game_over, bus.step, bus.head_x, bus.head_y} !== {1'b1, 1'b0, 3'd7, 3'd4}) begin
      failures++;
      $display("FAIL wall_right: got go=%b step=%b head=(%0d,%0d) expected 1 0 (7,4)",
               bus.game_over, bus.step, bus.head_x, bus.head_y);
    end
`endif
  endtask

  task automatic test_async_reset();
    int n;
    bus.start = 1'b1;
    repeat (3) cyc();
    bus.start = 1'b0;
    wait_move(n);
`ifdef COBRA_WRAP_EN
    bus.query_x = 3'd1;
`else
    bus.query_x = 3'd5;
`endif
    bus.query_y = 3'd4;
    checks++;
    if ({bus.step, bus.head_x, bus.head_y} !== {1'b1, bus.query_x, 3'd4}) begin
      failures++;
      $display("FAIL pre_reset_move: got step=%b head=(%0d,%0d) expected 1 (%0d,4)",
               bus.step, bus.head_x, bus.head_y, bus.query_x);
    end
    cyc();
    checks++;
    if (bus.query_hit !== 1'b1) begin
      failures++; $display("FAIL query_head: got %b expected 1", bus.query_hit);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.head_x, bus.head_y, bus.length, bus.step, bus.game_over, bus.query_hit}
        !== {3'd4, 3'd4, 3'd3, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got head=(%0d,%0d) len=%0d step=%b go=%b hit=%b expected (4,4) 3 0 0 0",
               bus.head_x, bus.head_y, bus.length, bus.step, bus.game_over, bus.query_hit);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_reverse();
    test_grow();
    test_self_collision();
    test_wall();
    test_async_reset();
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
